// File: rtl/console_bus_arbiter.sv
// rtl/console_bus_arbiter.sv - shares the console bus between the 6809E CPU and NUM_REQ requesters
// Round-robin grant with a per-grant hold limit; BA/BS are only trusted on E falling edges.
module console_bus_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               e,
  input  logic               bus_available,
  input  logic               bus_status,
  input  logic [NUM_REQ-1:0] req,
  output logic               n_breq,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               lost_bus
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [2:0] {IDLE, REQ_BUS, GRANT, RELEASE, CPU_RET} state_t;

  state_t        state;
  logic          e_q;
  logic          gnt_seen;
  logic          regrant_used;
  logic [2:0]    rr_ptr;
  logic [HW-1:0] hold_cnt;

  logic               e_fall;
  logic               bus_gnt;
  logic               gnt_now;
  logic [7:0]         req8;
  logic [NUM_REQ-1:0] own_mask;
  logic [NUM_REQ-1:0] cand;
  logic [7:0]         cand8;
  logic               pick_any;
  logic [2:0]         pick_idx;
  logic [3:0]         slot;
  logic [2:0]         next_ptr;

  assign e_fall   = e_q & ~e;
  assign bus_gnt  = bus_available & bus_status;
  // A fresh sample this cycle overrides the stored one so a grant never outruns BA/BS.
  assign gnt_now  = e_fall ? bus_gnt : gnt_seen;
  assign req8     = 8'(req);
  assign own_mask = NUM_REQ'(1) << owner;
  assign next_ptr = (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;

  // On a back-to-back handover the outgoing owner is not a candidate.
  always_comb begin
    cand = req;
    if (state == RELEASE) cand = req & ~own_mask;
  end

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    cand8    = 8'(cand);
    pick_any = 1'b0;
    pick_idx = 3'd0;
    slot     = 4'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      slot = {1'b0, rr_ptr} + 4'(i);
      if (slot >= 4'(NUM_REQ)) slot = slot - 4'(NUM_REQ);
      if (cand8[slot[2:0]]) begin
        pick_any = 1'b1;
        pick_idx = slot[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      e_q          <= 1'b1;
      gnt_seen     <= 1'b0;
      regrant_used <= 1'b0;
      rr_ptr       <= 3'd0;
      hold_cnt     <= '0;
      n_breq       <= 1'b1;
      grant        <= '0;
      owner        <= 3'd0;
      busy         <= 1'b0;
      lost_bus     <= 1'b0;
    end else begin
      e_q      <= e;
      lost_bus <= 1'b0;
      if (e_fall) gnt_seen <= bus_gnt;
      case (state)
        IDLE: begin
          if (|req) begin
            state        <= REQ_BUS;
            n_breq       <= 1'b0;
            busy         <= 1'b1;
            regrant_used <= 1'b0;
          end
        end
        REQ_BUS: begin
          if (~|req) begin
            state  <= CPU_RET;
            n_breq <= 1'b1;
          end else if (e_fall && bus_gnt && pick_any) begin
            state    <= GRANT;
            grant    <= NUM_REQ'(1) << pick_idx;
            owner    <= pick_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (e_fall && !bus_gnt) begin
            state    <= CPU_RET;
            grant    <= '0;
            lost_bus <= 1'b1;
            n_breq   <= 1'b1;
            rr_ptr   <= next_ptr;
          end else if (!req8[owner] || hold_cnt == HOLD_LAST) begin
            state  <= RELEASE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end else begin
            // Reaching HOLD_LAST always exits above, so this increment saturates.
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (pick_any && gnt_now && !regrant_used) begin
            state        <= GRANT;
            grant        <= NUM_REQ'(1) << pick_idx;
            owner        <= pick_idx;
            hold_cnt     <= '0;
            regrant_used <= 1'b1;
          end else begin
            state  <= CPU_RET;
            n_breq <= 1'b1;
          end
        end
        CPU_RET: begin
          if (e_fall && !bus_available) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
